// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates NMI/INT, runs the INA/INTD acknowledge handshake
// and issues a one-cycle dispatch pulse carrying the handler vector and cause.
module interrupt_sequencer #(
  parameter logic [31:0] INT_BASE    = 32'h0000_0100,
  parameter logic [31:0] NMI_VECTOR  = 32'h0000_0080,
  parameter logic [31:0] SPUR_VECTOR = 32'h0000_00C0,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        NMI,
  input  logic        INTD,
  input  logic [3:0]  dev_id,
  output logic        INA,
  input  logic        at_boundary,
  input  logic        ei_cmd,
  input  logic        di_cmd,
  input  logic        eret,
  output logic        hold_fetch,
  output logic        take_int,
  output logic [31:0] vector,
  output logic [1:0]  cause,
  output logic        ie,
  output logic        in_nmi
);

  typedef enum logic [1:0] {IDLE, ACK_WAIT, DISPATCH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        ina_nxt, take_nxt, take_nmi;
  logic [31:0] vector_nxt;
  logic [1:0]  cause_nxt;
  logic        nmi_q, nmi_pend, prev_ie;
  logic        nmi_rise, nmi_ok, int_ok;

  assign nmi_rise   = NMI & ~nmi_q;
  assign nmi_ok     = nmi_pend & ~in_nmi;
  assign int_ok     = INT & ie & ~in_nmi & ~nmi_ok;
  assign hold_fetch = (state != IDLE) | (at_boundary & (nmi_ok | int_ok));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ina_nxt    = INA;
    take_nxt   = 1'b0;
    vector_nxt = 32'h0;
    cause_nxt  = 2'b00;
    take_nmi   = 1'b0;
    case (state)
      IDLE: begin
        if (at_boundary && nmi_ok) begin
          state_nxt  = DISPATCH;
          take_nxt   = 1'b1;
          vector_nxt = NMI_VECTOR;
          cause_nxt  = 2'b10;
          take_nmi   = 1'b1;
        end else if (at_boundary && int_ok) begin
          state_nxt = ACK_WAIT;
          ina_nxt   = 1'b1;
          cnt_nxt   = 8'(ACK_TIMEOUT);
        end
      end
      ACK_WAIT: begin
        if (INTD) begin
          state_nxt  = DISPATCH;
          ina_nxt    = 1'b0;
          take_nxt   = 1'b1;
          vector_nxt = INT_BASE + {25'b0, dev_id, 3'b000};
          cause_nxt  = 2'b01;
        end else if (cnt == 8'd1) begin
          // Device never answered: dispatch to the spurious handler instead.
          state_nxt  = DISPATCH;
          ina_nxt    = 1'b0;
          take_nxt   = 1'b1;
          vector_nxt = SPUR_VECTOR;
          cause_nxt  = 2'b11;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DISPATCH: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      INA      <= 1'b0;
      take_int <= 1'b0;
      vector   <= 32'h0;
      cause    <= 2'b00;
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      INA      <= ina_nxt;
      take_int <= take_nxt;
      vector   <= vector_nxt;
      cause    <= cause_nxt;
      nmi_q    <= NMI;
      nmi_pend <= (nmi_pend & ~take_nmi) | nmi_rise;
    end
  end

  // Dispatch masks further interrupts and overrides any ei/di/eret in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie      <= 1'b0;
      prev_ie <= 1'b0;
      in_nmi  <= 1'b0;
    end else if (state == DISPATCH) begin
      prev_ie <= ie;
      ie      <= 1'b0;
      if (cause == 2'b10) in_nmi <= 1'b1;
      else if (eret)      in_nmi <= 1'b0;
    end else if (eret) begin
      ie     <= prev_ie;
      in_nmi <= 1'b0;
    end else if (di_cmd) begin
      ie <= 1'b0;
    end else if (ei_cmd) begin
      ie <= 1'b1;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer; inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, INT, NMI, INTD, at_boundary, ei_cmd, di_cmd, eret;
  logic [3:0]  dev_id;
  logic        INA, hold_fetch, take_int, ie, in_nmi;
  logic [31:0] vector;
  logic [1:0]  cause;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int seen;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .INT(INT), .NMI(NMI), .INTD(INTD), .dev_id(dev_id),
    .INA(INA), .at_boundary(at_boundary), .ei_cmd(ei_cmd), .di_cmd(di_cmd),
    .eret(eret), .hold_fetch(hold_fetch), .take_int(take_int), .vector(vector),
    .cause(cause), .ie(ie), .in_nmi(in_nmi)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; INT = 0; NMI = 0; INTD = 0; at_boundary = 0;
    ei_cmd = 0; di_cmd = 0; eret = 0; dev_id = 4'd0;
    applyStimulus(2);
    checkOutput("rst_ina", INA, 0);
    checkOutput("rst_take", take_int, 0);
    checkOutput("rst_vector", vector, 0);
    checkOutput("rst_cause", cause, 0);
    checkOutput("rst_ie", ie, 0);
    checkOutput("rst_in_nmi", in_nmi, 0);
    checkOutput("rst_hold", hold_fetch, 0);
    rst = 1'b0;

    // NMI dispatch
    $display("[TB] NMI dispatch");
    at_boundary = 1; NMI = 1;
    applyStimulus(1);
    checkOutput("nmi_hold_pend", hold_fetch, 1);
    checkOutput("nmi_take_early", take_int, 0);
    applyStimulus(1);
    checkOutput("nmi_take", take_int, 1);
    checkOutput("nmi_cause", cause, 2'b10);
    checkOutput("nmi_vector", vector, 32'h80);
    checkOutput("nmi_hold", hold_fetch, 1);
    NMI = 0;
    applyStimulus(1);
    checkOutput("nmi_in_nmi", in_nmi, 1);
    checkOutput("nmi_take_done", take_int, 0);
    checkOutput("nmi_vector_clr", vector, 0);
    eret = 1; applyStimulus(1); eret = 0;
    checkOutput("nmi_eret_in_nmi", in_nmi, 0);
    checkOutput("nmi_eret_ie", ie, 0);

    // INT handshake with device answering
    $display("[TB] INT handshake");
    ei_cmd = 1; applyStimulus(1); ei_cmd = 0;
    checkOutput("int_ie_set", ie, 1);
    INT = 1; #1;
    checkOutput("int_hold_req", hold_fetch, 1);
    applyStimulus(1);
    checkOutput("int_ina", INA, 1);
    at_boundary = 0;
    applyStimulus(2);
    checkOutput("int_ina_wait", INA, 1);
    checkOutput("int_hold_wait", hold_fetch, 1);
    INTD = 1; dev_id = 4'd5; INT = 0;
    applyStimulus(1);
    INTD = 0;
    checkOutput("int_ina_drop", INA, 0);
    checkOutput("int_take", take_int, 1);
    checkOutput("int_cause", cause, 2'b01);
    checkOutput("int_vector", vector, 32'h128);
    applyStimulus(1);
    checkOutput("int_take_done", take_int, 0);
    checkOutput("int_ie_clr", ie, 0);
    eret = 1; applyStimulus(1); eret = 0;
    checkOutput("int_eret_ie", ie, 1);

    // Spurious timeout: INA high exactly ACK_TIMEOUT cycles
    $display("[TB] spurious timeout");
    INT = 1; at_boundary = 1;
    applyStimulus(1);
    checkOutput("spur_ina_start", INA, 1);
    INT = 0; at_boundary = 0;
    seen = 1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1);
      if (INA) seen++;
    end
    checkOutput("spur_ina_cycles", seen, 8);
    applyStimulus(1);
    checkOutput("spur_ina_drop", INA, 0);
    checkOutput("spur_take", take_int, 1);
    checkOutput("spur_cause", cause, 2'b11);
    checkOutput("spur_vector", vector, 32'hC0);
    applyStimulus(1);
    checkOutput("spur_ie_clr", ie, 0);
    eret = 1; applyStimulus(1); eret = 0;
    checkOutput("spur_eret_ie", ie, 1);

    // Priority: pending NMI beats INT at the same boundary
    $display("[TB] priority and nesting");
    NMI = 1;
    applyStimulus(1);
    INT = 1; at_boundary = 1;
    applyStimulus(1);
    checkOutput("prio_take", take_int, 1);
    checkOutput("prio_cause", cause, 2'b10);
    checkOutput("prio_ina", INA, 0);
    NMI = 0;
    applyStimulus(1);
    checkOutput("prio_in_nmi", in_nmi, 1);
    checkOutput("prio_ie_clr", ie, 0);
    applyStimulus(1);
    checkOutput("prio_no_int", INA, 0);
    NMI = 1; applyStimulus(1); NMI = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      if (take_int || hold_fetch) seen++;
    end
    checkOutput("nest_blocked", seen, 0);
    eret = 1; applyStimulus(1); eret = 0;
    checkOutput("nest_eret_in_nmi", in_nmi, 0);
    checkOutput("nest_eret_ie", ie, 1);
    checkOutput("nest_hold", hold_fetch, 1);
    applyStimulus(1);
    checkOutput("nest_take", take_int, 1);
    checkOutput("nest_cause", cause, 2'b10);
    checkOutput("nest_ina", INA, 0);
    INT = 0;
    applyStimulus(1);
    eret = 1; applyStimulus(1); eret = 0;
    checkOutput("nest_final_ie", ie, 1);

    // Masking: ie=0, then at_boundary=0
    $display("[TB] masking");
    di_cmd = 1; applyStimulus(1); di_cmd = 0;
    checkOutput("mask_ie_clr", ie, 0);
    INT = 1; at_boundary = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (take_int || INA || hold_fetch) seen++;
    end
    checkOutput("mask_ie_quiet", seen, 0);
    at_boundary = 0;
    ei_cmd = 1; applyStimulus(1); ei_cmd = 0;
    checkOutput("mask_ie_set", ie, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (take_int || INA || hold_fetch) seen++;
    end
    checkOutput("mask_bnd_quiet", seen, 0);
    INT = 0;

    // Reset during ACK_WAIT
    $display("[TB] reset mid-handshake");
    INT = 1; at_boundary = 1;
    applyStimulus(1);
    checkOutput("rstmid_ina", INA, 1);
    INT = 0; at_boundary = 0;
    applyStimulus(1);
    rst = 1; applyStimulus(1); rst = 0;
    checkOutput("rstmid_ina_drop", INA, 0);
    checkOutput("rstmid_ie", ie, 0);
    checkOutput("rstmid_hold", hold_fetch, 0);
    INTD = 1; dev_id = 4'd3;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      if (take_int) seen++;
    end
    INTD = 0;
    checkOutput("rstmid_no_take", seen, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
